// File: rtl/axi_master.sv
// axi_master: single-outstanding AXI4 initiator.
// Converts a command / write-data / read-data / completion interface into
// AXI4 INCR bursts of full bus width, one completion per command.
// Optional build macro: AXI_MASTER_PERF_EN adds beat and error counters.
module axi_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_write,
    output logic [ID_WIDTH-1:0]   resp_id,
    output logic [1:0]            resp_code,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
`ifdef AXI_MASTER_PERF_EN
    ,
    output logic [31:0]           perf_wr_beats,
    output logic [31:0]           perf_rd_beats,
    output logic [15:0]           perf_err_cnt
`endif
);

    localparam int                    SIZE      = $clog2(STRB_WIDTH);
    localparam logic [2:0]            AXSIZE    = 3'(SIZE);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'((1 << SIZE) - 1));

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_AR   = 3'd4;
    localparam logic [2:0] S_R    = 3'd5;
    localparam logic [2:0] S_RESP = 3'd6;

    logic [2:0]            state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic                  write_q, write_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [1:0]            resp_code_q, resp_code_d;
    logic                  awvalid_q, awvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  live_q;

    logic in_w, in_r, w_hs, r_hs;

    // IDs of returning beats are deliberately ignored (single outstanding).
    logic unused_ids;
    assign unused_ids = &{1'b0, m_axi_bid, m_axi_rid};

    assign in_w = (state_q == S_W);
    assign in_r = (state_q == S_R);
    assign w_hs = in_w && wr_valid && m_axi_wready;
    assign r_hs = in_r && m_axi_rvalid && rd_ready;

    // Next-state and datapath register computation for the burst sequencer.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        write_d     = write_q;
        beat_cnt_d  = beat_cnt_q;
        resp_code_d = resp_code_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    id_d        = cmd_id;
                    addr_d      = cmd_addr & ADDR_MASK;
                    len_d       = cmd_len;
                    write_d     = cmd_write;
                    beat_cnt_d  = cmd_len;
                    resp_code_d = 2'b00;
                    state_d     = cmd_write ? S_AW : S_AR;
                end
            end
            S_AW: if (m_axi_awready) state_d = S_W;
            S_W: begin
                if (w_hs) begin
                    beat_cnt_d = beat_cnt_q - 8'd1;
                    if (beat_cnt_q == 8'd0) state_d = S_B;
                end
            end
            S_B: begin
                if (m_axi_bvalid) begin
                    resp_code_d = m_axi_bresp;
                    state_d     = S_RESP;
                end
            end
            S_AR: if (m_axi_arready) state_d = S_R;
            S_R: begin
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q - 8'd1;
                    // A last flag that disagrees with the beat count is a
                    // responder protocol error and overrides any rresp.
                    if (m_axi_rlast != (beat_cnt_q == 8'd0)) begin
                        resp_code_d = 2'b10;
                    end else if (resp_code_q == 2'b00 && m_axi_rresp != 2'b00) begin
                        resp_code_d = m_axi_rresp;
                    end
                    if (m_axi_rlast) state_d = S_RESP;
                end
            end
            S_RESP: if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign awvalid_d = (state_d == S_AW);
    assign arvalid_d = (state_d == S_AR);

    // State and datapath registers; reset abandons any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            write_q     <= 1'b0;
            beat_cnt_q  <= '0;
            resp_code_q <= 2'b00;
            awvalid_q   <= 1'b0;
            arvalid_q   <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            write_q     <= write_d;
            beat_cnt_q  <= beat_cnt_d;
            resp_code_q <= resp_code_d;
            awvalid_q   <= awvalid_d;
            arvalid_q   <= arvalid_d;
            live_q      <= 1'b1;
        end
    end

    // live_q keeps cmd_ready low while reset is held.
    assign cmd_ready = live_q && (state_q == S_IDLE);

    assign m_axi_awid    = id_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = awvalid_q ? AXSIZE : 3'd0;
    assign m_axi_awburst = awvalid_q ? 2'b01 : 2'b00;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'd0;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_awvalid = awvalid_q;

    assign m_axi_arid    = id_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = arvalid_q ? AXSIZE : 3'd0;
    assign m_axi_arburst = arvalid_q ? 2'b01 : 2'b00;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arvalid = arvalid_q;

    assign m_axi_wvalid = in_w && wr_valid;
    assign wr_ready     = in_w && m_axi_wready;
    assign m_axi_wdata  = in_w ? wr_data : '0;
    assign m_axi_wstrb  = in_w ? wr_strb : '0;
    assign m_axi_wlast  = in_w && (beat_cnt_q == 8'd0);
    assign m_axi_bready = (state_q == S_B);

    assign rd_valid     = in_r && m_axi_rvalid;
    assign m_axi_rready = in_r && rd_ready;
    assign rd_data      = in_r ? m_axi_rdata : '0;
    assign rd_last      = in_r && m_axi_rlast;

    assign resp_valid = (state_q == S_RESP);
    assign resp_write = write_q;
    assign resp_id    = id_q;
    assign resp_code  = resp_code_q;

`ifdef AXI_MASTER_PERF_EN
    logic [31:0] perf_wr_q, perf_wr_d, perf_rd_q, perf_rd_d;
    logic [15:0] perf_err_q, perf_err_d;

    // Free-running wrap-around counters of data beats and failed completions.
    always_comb begin
        perf_wr_d  = perf_wr_q + 32'(w_hs);
        perf_rd_d  = perf_rd_q + 32'(r_hs);
        perf_err_d = perf_err_q + 16'(resp_valid && resp_ready && (resp_code_q != 2'b00));
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_wr_q  <= '0;
            perf_rd_q  <= '0;
            perf_err_q <= '0;
        end else begin
            perf_wr_q  <= perf_wr_d;
            perf_rd_q  <= perf_rd_d;
            perf_err_q <= perf_err_d;
        end
    end

    assign perf_wr_beats = perf_wr_q;
    assign perf_rd_beats = perf_rd_q;
    assign perf_err_cnt  = perf_err_q;
`endif

endmodule

// File: tb/tb_axi_master.sv
// tb_axi_master: directed bench for axi_master with a small AXI RAM responder
// and a queue-based scoreboard for read beats and completions.
module tb_axi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_id, cmd_len;
    logic [15:0] cmd_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_last, rd_valid, rd_ready;
    logic        resp_valid, resp_ready, resp_write;
    logic [7:0]  resp_id;
    logic [1:0]  resp_code;
    logic [7:0]  m_axi_awid, m_axi_awlen, m_axi_arid, m_axi_arlen;
    logic [15:0] m_axi_awaddr, m_axi_araddr;
    logic [2:0]  m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
    logic [1:0]  m_axi_awburst, m_axi_arburst;
    logic        m_axi_awlock, m_axi_arlock;
    logic [3:0]  m_axi_awcache, m_axi_arcache;
    logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_wdata, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [7:0]  m_axi_bid, m_axi_rid;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    axi_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_id(resp_id), .resp_code(resp_code),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [31:0] data; logic last; } rd_t;
    typedef struct packed { logic w; logic [7:0] id; logic [1:0] code; } resp_t;
    rd_t   exp_rd[$];
    resp_t exp_resp[$];

    logic [31:0] wdat [0:3];
    logic [31:0] rexp [0:3];
    logic [15:0] exp_addr;
    int          exp_len;
    int          aw_delay   = 0;
    int          fault_beat = -1;
    bit          stall_rd   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    // ---------------- responder: AXI RAM with optional stalls / rlast fault
    logic [31:0] mem [0:255];
    initial begin
        logic aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_stalled;
        logic [15:0] cap_awaddr, cap_araddr, held_addr, wa, ra;
        logic [7:0]  cap_awlen, cap_arlen, held_len;
        logic [2:0]  cap_awsize, cap_arsize;
        logic [1:0]  cap_awburst, cap_arburst;
        logic [31:0] cap_wdata;
        logic [3:0]  cap_wstrb;
        logic        cap_wlast;
        int          aw_wait, w_beat, rlen, rbeat;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        m_axi_awready = 0; m_axi_wready = 1; m_axi_arready = 1;
        m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_bid = 0;
        m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rlast = 0; m_axi_rresp = 0; m_axi_rid = 0;
        aw_stalled = 0; aw_wait = 0; w_beat = 0; rlen = 0; rbeat = 0;
        wa = 0; ra = 0; held_addr = 0; held_len = 0;
        forever begin
            @(negedge clk);
            aw_hs = m_axi_awvalid && m_axi_awready;
            w_hs  = m_axi_wvalid && m_axi_wready;
            b_hs  = m_axi_bvalid && m_axi_bready;
            ar_hs = m_axi_arvalid && m_axi_arready;
            r_hs  = m_axi_rvalid && m_axi_rready;
            cap_awaddr = m_axi_awaddr; cap_awlen = m_axi_awlen;
            cap_awsize = m_axi_awsize; cap_awburst = m_axi_awburst;
            cap_araddr = m_axi_araddr; cap_arlen = m_axi_arlen;
            cap_arsize = m_axi_arsize; cap_arburst = m_axi_arburst;
            cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb; cap_wlast = m_axi_wlast;
            if (!rst && aw_stalled) begin
                check("aw_hold_valid", m_axi_awvalid, 1'b1);
                check("aw_hold_addr", m_axi_awaddr, held_addr);
                check("aw_hold_len", m_axi_awlen, held_len);
            end
            aw_stalled = !rst && m_axi_awvalid && !m_axi_awready;
            held_addr = m_axi_awaddr;
            held_len  = m_axi_awlen;
            @(posedge clk);
            #1;
            if (rst) begin
                m_axi_awready = 0; m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
                aw_wait = 0; w_beat = 0; aw_stalled = 0;
                continue;
            end
            if (aw_hs) begin
                check("awaddr", cap_awaddr, exp_addr);
                check("awlen", cap_awlen, 8'(exp_len));
                check("awsize", cap_awsize, 3'd2);
                check("awburst", cap_awburst, 2'b01);
                m_axi_awready = 0; aw_wait = 0; wa = cap_awaddr; w_beat = 0;
            end else if (m_axi_awvalid && !m_axi_awready) begin
                if (aw_wait >= aw_delay) m_axi_awready = 1;
                else aw_wait++;
            end
            if (w_hs) begin
                check("wlast", cap_wlast, w_beat == exp_len);
                for (int k = 0; k < 4; k++)
                    if (cap_wstrb[k]) mem[wa[9:2]][8*k +: 8] = cap_wdata[8*k +: 8];
                w_beat++; wa = wa + 16'd4;
                if (cap_wlast) begin m_axi_bvalid = 1; m_axi_bresp = 2'b00; end
            end
            if (b_hs) m_axi_bvalid = 0;
            if (ar_hs) begin
                check("araddr", cap_araddr, exp_addr);
                check("arlen", cap_arlen, 8'(exp_len));
                check("arsize", cap_arsize, 3'd2);
                check("arburst", cap_arburst, 2'b01);
                ra = cap_araddr; rlen = int'(cap_arlen); rbeat = 0;
                m_axi_rvalid = 1; m_axi_rdata = mem[ra[9:2]];
                m_axi_rlast = (rbeat == rlen) || (rbeat == fault_beat);
            end else if (r_hs) begin
                if (m_axi_rlast) begin
                    m_axi_rvalid = 0; m_axi_rlast = 0;
                end else begin
                    rbeat++; ra = ra + 16'd4;
                    m_axi_rdata = mem[ra[9:2]];
                    m_axi_rlast = (rbeat == rlen) || (rbeat == fault_beat);
                end
            end
        end
    end

    // ---------------- rd_ready pattern: steady high, or 1-0-1 when stalling
    initial begin
        int cyc = 0;
        rd_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            rd_ready = stall_rd ? ((cyc % 3) != 1) : 1'b1;
            cyc++;
        end
    end

    // ---------------- monitor: pops the scoreboard on every output handshake
    initial begin
        rd_t   er;
        resp_t ep;
        forever begin
            @(negedge clk);
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) begin
                    check("rd_unexpected", 1'b1, 1'b0);
                end else begin
                    er = exp_rd.pop_front();
                    $display("rd beat data=%08h last=%0d", rd_data, rd_last);
                    check("rd_data", rd_data, er.data);
                    check("rd_last", rd_last, er.last);
                end
            end
            if (resp_valid && resp_ready) begin
                $display("resp write=%0d id=%02h code=%0d", resp_write, resp_id, resp_code);
                if (exp_resp.size() == 0) begin
                    check("resp_unexpected", 1'b1, 1'b0);
                end else begin
                    ep = exp_resp.pop_front();
                    check("resp_write", resp_write, ep.w);
                    check("resp_id", resp_id, ep.id);
                    check("resp_code", resp_code, ep.code);
                end
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic issue_cmd(input logic w, input logic [7:0] id, input logic [15:0] addr,
                             input int len);
        int n = 0;
        @(posedge clk);
        #1;
        cmd_write = w; cmd_id = id; cmd_addr = addr; cmd_len = 8'(len);
        exp_addr = addr & 16'hFFFC;
        exp_len  = len;
        cmd_valid = 1;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            if (++n > 200) begin fail_timeout("cmd_accept"); break; end
        end
        @(posedge clk);
        #1;
        cmd_valid = 0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wr_valid = 1; wr_data = d; wr_strb = s;
        forever begin
            @(negedge clk);
            if (wr_ready) break;
            if (++n > 200) begin fail_timeout("wr_beat"); break; end
        end
        @(posedge clk);
        #1;
        wr_valid = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        forever begin
            @(negedge clk);
            if (exp_resp.size() == 0 && exp_rd.size() == 0) break;
            if (++n > 500) begin
                fail_timeout("completion");
                exp_resp.delete();
                exp_rd.delete();
                break;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1'b1);
    endtask

    task automatic do_write(input logic [7:0] id, input logic [15:0] addr, input int len,
                            input logic [3:0] strb);
        $display("write id=%02h addr=%04h len=%0d strb=%h", id, addr, len, strb);
        exp_resp.push_back('{w: 1'b1, id: id, code: 2'b00});
        issue_cmd(1'b1, id, addr, len);
        for (int b = 0; b <= len; b++) send_beat(wdat[b], strb);
        wait_done();
    endtask

    task automatic do_read(input logic [7:0] id, input logic [15:0] addr, input int len,
                           input int nbeats, input logic [1:0] code);
        $display("read id=%02h addr=%04h len=%0d", id, addr, len);
        for (int b = 0; b < nbeats; b++)
            exp_rd.push_back('{data: rexp[b], last: (b == nbeats - 1)});
        exp_resp.push_back('{w: 1'b0, id: id, code: code});
        issue_cmd(1'b0, id, addr, len);
        wait_done();
    endtask

    // ---------------- main sequence
    initial begin
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_id = 0; cmd_addr = 0; cmd_len = 0;
        wr_data = 0; wr_strb = 0; wr_valid = 0; resp_ready = 1;
        exp_addr = 0; exp_len = 0;

        // Reset state: every valid/ready low while reset is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_awvalid", m_axi_awvalid, 1'b0);
        check("rst_arvalid", m_axi_arvalid, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("post_rst_ready_early", cmd_ready, 1'b0);
        @(negedge clk);
        check("post_rst_ready", cmd_ready, 1'b1);

        // 4-beat write then read back.
        wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
        do_write(8'h21, 16'h0010, 3, 4'hF);
        rexp[0] = 32'h11; rexp[1] = 32'h22; rexp[2] = 32'h33; rexp[3] = 32'h44;
        do_read(8'h22, 16'h0010, 3, 4, 2'b00);

        // Single-beat partial-strobe write over an all-ones word.
        wdat[0] = 32'hFFFF_FFFF;
        do_write(8'h30, 16'h0040, 0, 4'hF);
        wdat[0] = 32'hAABB_CCDD;
        do_write(8'h31, 16'h0040, 0, 4'h3);
        rexp[0] = 32'hFFFF_CCDD;
        do_read(8'h32, 16'h0040, 0, 1, 2'b00);

        // Delayed awready and a toggling rd_ready.
        aw_delay = 5;
        wdat[0] = 32'h0102_0304; wdat[1] = 32'h0506_0708;
        wdat[2] = 32'h090A_0B0C; wdat[3] = 32'h0D0E_0F10;
        do_write(8'h40, 16'h0080, 3, 4'hF);
        aw_delay = 0;
        stall_rd = 1;
        rexp[0] = 32'h0102_0304; rexp[1] = 32'h0506_0708;
        rexp[2] = 32'h090A_0B0C; rexp[3] = 32'h0D0E_0F10;
        do_read(8'h41, 16'h0080, 3, 4, 2'b00);
        stall_rd = 0;

        // Early rlast on beat 2 of a 4-beat read; unaligned start address.
        fault_beat = 1;
        rexp[0] = 32'h11; rexp[1] = 32'h22;
        do_read(8'h50, 16'h0012, 3, 2, 2'b10);
        fault_beat = -1;

        // Reset in the middle of the second W beat: no completion expected.
        $display("write id=55 addr=00c0 len=3 interrupted by reset");
        issue_cmd(1'b1, 8'h55, 16'h00C0, 3);
        send_beat(32'hDEAD_0001, 4'hF);
        wr_valid = 1; wr_data = 32'hDEAD_0002; wr_strb = 4'hF;
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        check("mid_rst_wvalid", m_axi_wvalid, 1'b0);
        check("mid_rst_wr_ready", wr_ready, 1'b0);
        check("mid_rst_bready", m_axi_bready, 1'b0);
        check("mid_rst_resp_valid", resp_valid, 1'b0);
        check("mid_rst_cmd_ready", cmd_ready, 1'b0);
        wr_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        repeat (4) @(negedge clk);

        // Normal traffic after the abandoned burst.
        wdat[0] = 32'hCAFE_F00D;
        do_write(8'h60, 16'h00C0, 0, 4'hF);
        rexp[0] = 32'hCAFE_F00D;
        do_read(8'h61, 16'h00C0, 0, 1, 2'b00);

        check("exp_rd_empty", 32'(exp_rd.size()), 32'd0);
        check("exp_resp_empty", 32'(exp_resp.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard so a stuck DUT still produces a summary.
    initial begin
        #200000;
        fail_timeout("global");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
